// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a 64-bit synchronous scratch memory.
// Ports: clock/reset, AW/W/B and AR/R slave channels (in_* prefix).
// Read and write each run one transaction at a time (FIXED/INCR bursts).
// Out-of-range beats answer DECERR; WRAP, reserved bursts and size>3
// answer SLVERR.
// Optional macro AXI4_SRAM_STALL_EN adds LFSR-driven W/R back-pressure.
module axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          DEPTH_LOG2    = 12,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_awready,
    input  logic        in_awvalid,
    input  logic [3:0]  in_awid,
    input  logic [31:0] in_awaddr,
    input  logic [7:0]  in_awlen,
    input  logic [2:0]  in_awsize,
    input  logic [1:0]  in_awburst,
    output logic        in_wready,
    input  logic        in_wvalid,
    input  logic [63:0] in_wdata,
    input  logic [7:0]  in_wstrb,
    input  logic        in_wlast,
    input  logic        in_bready,
    output logic        in_bvalid,
    output logic [3:0]  in_bid,
    output logic [1:0]  in_bresp,
    output logic        in_arready,
    input  logic        in_arvalid,
    input  logic [3:0]  in_arid,
    input  logic [31:0] in_araddr,
    input  logic [7:0]  in_arlen,
    input  logic [2:0]  in_arsize,
    input  logic [1:0]  in_arburst,
    input  logic        in_rready,
    output logic        in_rvalid,
    output logic [3:0]  in_rid,
    output logic [63:0] in_rdata,
    output logic [1:0]  in_rresp,
    output logic        in_rlast
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'd8 << DEPTH_LOG2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [31:0] step(input logic [1:0] burst,
                                         input logic [2:0] size);
        logic [2:0] s;
        s = (size > 3'd3) ? 3'd3 : size;
        return (burst == 2'b00) ? 32'd0 : (32'd1 << s);
    endfunction

    function automatic logic attr_err(input logic [1:0] burst,
                                      input logic [2:0] size);
        return burst[1] || (size > 3'd3);
    endfunction

    logic [63:0] mem [DEPTH];
    logic        stall;

`ifdef AXI4_SRAM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [3:0]  r_cnt, r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_hs, r_launch;

    assign in_arready = (r_state == R_IDLE);
    assign r_hs       = in_rvalid && in_rready;

    // r_launch loads the next beat into the R output registers.
    always_comb begin
        r_next   = r_state;
        r_launch = 1'b0;
        unique case (r_state)
            R_IDLE:  if (in_arvalid) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) begin
                r_next   = R_BURST;
                r_launch = !stall;
            end
            R_BURST: begin
                if (r_hs && in_rlast) r_next = R_IDLE;
                else r_launch = (!in_rvalid || r_hs) && !stall;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_cnt     <= 4'd0;
            r_id      <= 4'd0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_beat    <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
            in_rvalid <= 1'b0;
            in_rid    <= 4'd0;
            in_rdata  <= 64'd0;
            in_rresp  <= 2'd0;
            in_rlast  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && in_arvalid) begin
                r_id    <= in_arid;
                r_addr  <= in_araddr;
                r_len   <= in_arlen;
                r_size  <= in_arsize;
                r_burst <= in_arburst;
                r_beat  <= 8'd0;
                r_cnt   <= 4'(READ_LATENCY);
            end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // mem is read here before this edge's write lands,
            // so a same-cycle write to the word is not seen.
            if (r_launch) begin
                in_rvalid <= 1'b1;
                in_rid    <= r_id;
                in_rlast  <= (r_beat == r_len);
                if (in_range(r_addr)) begin
                    in_rdata <= mem[word_idx(r_addr)];
                    in_rresp <= attr_err(r_burst, r_size) ? 2'b10 : 2'b00;
                end else begin
                    in_rdata <= 64'd0;
                    in_rresp <= 2'b11;
                end
                r_addr <= r_addr + step(r_burst, r_size);
                r_beat <= r_beat + 8'd1;
            end else if (r_hs) begin
                in_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [3:0]  w_cnt, w_id;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_hs, w_dec, w_slv;

    assign in_awready = (w_state == W_IDLE);
    assign in_wready  = (w_state == W_DATA) && !stall;
    assign w_hs       = in_wvalid && in_wready;
    assign in_bvalid  = (w_state == W_RESP);
    assign in_bid     = w_id;
    assign in_bresp   = !in_bvalid ? 2'b00 :
                        w_dec ? 2'b11 : w_slv ? 2'b10 : 2'b00;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (in_awvalid) w_next = W_DATA;
            W_DATA: if (w_hs && w_beat == w_len) w_next = W_WAIT;
            W_WAIT: if (w_cnt == 4'd0) w_next = W_RESP;
            W_RESP: if (in_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            w_id    <= 4'd0;
            w_addr  <= 32'd0;
            w_len   <= 8'd0;
            w_beat  <= 8'd0;
            w_size  <= 3'd0;
            w_burst <= 2'd0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && in_awvalid) begin
                w_id    <= in_awid;
                w_addr  <= in_awaddr;
                w_len   <= in_awlen;
                w_size  <= in_awsize;
                w_burst <= in_awburst;
                w_beat  <= 8'd0;
                w_dec   <= 1'b0;
                w_slv   <= attr_err(in_awburst, in_awsize);
            end
            if (w_hs) begin
                if (!in_range(w_addr)) w_dec <= 1'b1;
                if (w_beat == w_len) begin
                    if (!in_wlast) w_slv <= 1'b1;
                    w_cnt <= 4'(WRITE_LATENCY);
                end else begin
                    if (in_wlast) w_slv <= 1'b1;
                    w_beat <= w_beat + 8'd1;
                    w_addr <= w_addr + step(w_burst, w_size);
                end
            end
            if (w_state == W_WAIT && w_cnt != 4'd0) w_cnt <= w_cnt - 4'd1;
        end
    end

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    assign mem_we  = w_hs && in_range(w_addr);
    assign mem_idx = word_idx(w_addr);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (in_wstrb[b]) mem[mem_idx][b*8 +: 8] <= in_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave.
// Expected R/B responses are queued at request time, checked on handshake.
module tb_axi4_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_awready, in_awvalid;
    logic [3:0]  in_awid;
    logic [31:0] in_awaddr;
    logic [7:0]  in_awlen;
    logic [2:0]  in_awsize;
    logic [1:0]  in_awburst;
    logic        in_wready, in_wvalid, in_wlast;
    logic [63:0] in_wdata;
    logic [7:0]  in_wstrb;
    logic        in_bready, in_bvalid;
    logic [3:0]  in_bid;
    logic [1:0]  in_bresp;
    logic        in_arready, in_arvalid;
    logic [3:0]  in_arid;
    logic [31:0] in_araddr;
    logic [7:0]  in_arlen;
    logic [2:0]  in_arsize;
    logic [1:0]  in_arburst;
    logic        in_rready, in_rvalid, in_rlast;
    logic [3:0]  in_rid;
    logic [63:0] in_rdata;
    logic [1:0]  in_rresp;

    axi4_sram_slave dut (
        .clock(clock), .reset(reset),
        .in_awready(in_awready), .in_awvalid(in_awvalid), .in_awid(in_awid),
        .in_awaddr(in_awaddr), .in_awlen(in_awlen), .in_awsize(in_awsize),
        .in_awburst(in_awburst),
        .in_wready(in_wready), .in_wvalid(in_wvalid), .in_wdata(in_wdata),
        .in_wstrb(in_wstrb), .in_wlast(in_wlast),
        .in_bready(in_bready), .in_bvalid(in_bvalid), .in_bid(in_bid),
        .in_bresp(in_bresp),
        .in_arready(in_arready), .in_arvalid(in_arvalid), .in_arid(in_arid),
        .in_araddr(in_araddr), .in_arlen(in_arlen), .in_arsize(in_arsize),
        .in_arburst(in_arburst),
        .in_rready(in_rready), .in_rvalid(in_rvalid), .in_rid(in_rid),
        .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rlast(in_rlast)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [63:0] model [int unsigned];
    logic [63:0] wd [8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic inr(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_8000);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        r_exp_t re;
        b_exp_t be;
        if (!reset && in_rvalid && in_rready) begin
            if (rq.size() == 0) begin
                check("r_extra", 1, 0);
            end else begin
                re = rq.pop_front();
                check("rdata", in_rdata, re.data);
                check("rresp", 64'(in_rresp), 64'(re.resp));
                check("rlast", 64'(in_rlast), 64'(re.last));
                check("rid", 64'(in_rid), 64'(re.id));
            end
        end
        if (!reset && in_bvalid && in_bready) begin
            if (bq.size() == 0) begin
                check("b_extra", 1, 0);
            end else begin
                be = bq.pop_front();
                check("bresp", 64'(in_bresp), 64'(be.resp));
                check("bid", 64'(in_bid), 64'(be.id));
            end
        end
    end

    task automatic wait_r();
        for (int i = 0; i < 200 && rq.size() > 0; i++) tick();
        if (rq.size() > 0) begin
            check("r_timeout", 64'(rq.size()), 0);
            rq.delete();
        end
    endtask

    task automatic wait_b();
        for (int i = 0; i < 100 && bq.size() > 0; i++) tick();
        if (bq.size() > 0) begin
            check("b_timeout", 64'(bq.size()), 0);
            bq.delete();
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic        hs;
        logic [31:0] a;
        r_exp_t      e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            if (inr(a)) begin
                e.data = model.exists(a >> 3) ? model[a >> 3] : 64'h0;
                e.resp = burst[1] ? 2'b10 : 2'b00;
            end else begin
                e.data = 64'h0;
                e.resp = 2'b11;
            end
            rq.push_back(e);
            if (burst != 2'b00) a += 32'd8;
        end
        in_arvalid = 1'b1;
        in_arid    = id;
        in_araddr  = addr;
        in_arlen   = len;
        in_arsize  = 3'd3;
        in_arburst = burst;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = in_arready;
            tick();
        end
        in_arvalid = 1'b0;
        if (!hs) check("ar_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] strb, input int last_at,
                          input logic [1:0] bresp);
        logic        hs;
        logic [31:0] a;
        logic [63:0] m;
        b_exp_t      be;
        be.resp = bresp;
        be.id   = id;
        bq.push_back(be);
        in_awvalid = 1'b1;
        in_awid    = id;
        in_awaddr  = addr;
        in_awlen   = len;
        in_awsize  = 3'd3;
        in_awburst = burst;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = in_awready;
            tick();
        end
        in_awvalid = 1'b0;
        if (!hs) check("aw_timeout", 0, 1);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            in_wvalid = 1'b1;
            in_wdata  = wd[i];
            in_wstrb  = strb;
            in_wlast  = (i == last_at);
            hs = 1'b0;
            for (int j = 0; j < 50 && !hs; j++) begin
                hs = in_wready;
                tick();
            end
            if (!hs) begin
                check("w_timeout", 0, 1);
            end else if (inr(a)) begin
                m = model.exists(a >> 3) ? model[a >> 3] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (strb[b]) m[b*8 +: 8] = wd[i][b*8 +: 8];
                model[a >> 3] = m;
            end
            if (burst != 2'b00) a += 32'd8;
        end
        in_wvalid = 1'b0;
        in_wlast  = 1'b0;
        wait_b();
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        in_awvalid = 1'b0; in_awid = '0; in_awaddr = '0; in_awlen = '0;
        in_awsize  = '0;   in_awburst = '0;
        in_wvalid  = 1'b0; in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0;
        in_bready  = 1'b1;
        in_arvalid = 1'b0; in_arid = '0; in_araddr = '0; in_arlen = '0;
        in_arsize  = '0;   in_arburst = '0;
        in_rready  = 1'b0;
        repeat (3) tick();
        check("rst_arready", 64'(in_arready), 1);
        check("rst_awready", 64'(in_awready), 1);
        check("rst_wready", 64'(in_wready), 0);
        check("rst_rvalid", 64'(in_rvalid), 0);
        check("rst_bvalid", 64'(in_bvalid), 0);
        check("rst_rdata", in_rdata, 0);
        check("rst_rid", 64'(in_rid), 0);
        check("rst_rresp", 64'(in_rresp), 0);
        check("rst_rlast", 64'(in_rlast), 0);
        check("rst_bid", 64'(in_bid), 0);
        check("rst_bresp", 64'(in_bresp), 0);
        reset = 1'b0;
        tick();

        // single read with latency
        wd[0] = 64'h1122_3344_5566_7788;
        w_send(4'd5, 32'h8000_0008, 8'd0, 2'b01, 8'hFF, 0, 2'b00);
        in_rready = 1'b1;
        ar_send(4'd3, 32'h8000_0008, 8'd0, 2'b01);
        n = 0;
        while (!in_rvalid && n < 20) begin
            tick();
            n++;
        end
        check("rd_lat", 64'(n), 3);
        wait_r();

        // INCR write/read
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        w_send(4'd7, 32'h8000_0100, 8'd3, 2'b01, 8'hFF, 3, 2'b00);
        ar_send(4'd2, 32'h8000_0100, 8'd3, 2'b01);
        wait_r();

        // partial strobe
        wd[0] = 64'h0;
        w_send(4'd1, 32'h8000_0200, 8'd0, 2'b01, 8'hFF, 0, 2'b00);
        wd[0] = '1;
        w_send(4'd1, 32'h8000_0200, 8'd0, 2'b01, 8'h0F, 0, 2'b00);
        ar_send(4'd1, 32'h8000_0200, 8'd0, 2'b01);
        wait_r();

        // out of range read and write
        wd[0] = 64'hDEAD_BEEF_0BAD_F00D;
        w_send(4'd2, 32'h8000_7FF8, 8'd0, 2'b01, 8'hFF, 0, 2'b00);
        ar_send(4'd6, 32'h7FFF_FFF8, 8'd1, 2'b00);
        wait_r();
        wd[0] = '1;
        w_send(4'd6, 32'h7FFF_FFF8, 8'd0, 2'b00, 8'hFF, 0, 2'b11);
        ar_send(4'd6, 32'h8000_7FF8, 8'd0, 2'b01);
        wait_r();

        // WRAP read answers SLVERR, advances as INCR
        ar_send(4'd9, 32'h8000_0100, 8'd1, 2'b10);
        wait_r();

        // early wlast
        wd[0] = 64'hA0; wd[1] = 64'hA1; wd[2] = 64'hA2;
        w_send(4'd3, 32'h8000_0300, 8'd2, 2'b01, 8'hFF, 1, 2'b10);
        ar_send(4'd3, 32'h8000_0300, 8'd2, 2'b01);
        wait_r();

        // rready held low mid-burst
        ar_send(4'd4, 32'h8000_0100, 8'd3, 2'b01);
        for (int i = 0; i < 50 && rq.size() > 3; i++) tick();
        in_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r_hold_v", 64'(in_rvalid), 1);
            if (rq.size() > 0) check("r_hold_d", in_rdata, rq[0].data);
        end
        in_rready = 1'b1;
        wait_r();

        // reset during R_BURST
        for (int i = 0; i < 8; i++) wd[i] = 64'h5500 + 64'(i);
        w_send(4'd8, 32'h8000_0400, 8'd7, 2'b01, 8'hFF, 7, 2'b00);
        in_rready = 1'b0;
        ar_send(4'd5, 32'h8000_0400, 8'd7, 2'b01);
        for (int i = 0; i < 20 && !in_rvalid; i++) tick();
        check("pre_rst_rvalid", 64'(in_rvalid), 1);
        in_rready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_rvalid", 64'(in_rvalid), 0);
        rq.delete();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_arready", 64'(in_arready), 1);
        ar_send(4'd5, 32'h8000_0408, 8'd0, 2'b01);
        wait_r();
        repeat (5) tick();
        check("r_left", 64'(rq.size()), 0);
        check("b_left", 64'(bq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 responder (slave end) backed by an internal 64-bit-wide synchronous memory.
- Terminates the master-side bus, e.g. downstream of a pass-through or delay stage, as a simulation/SoC scratch memory.
- Read and write channels are independent FSMs, with one outstanding transaction each.
- Supports FIXED and INCR bursts, programmable fixed response latency, and DECERR for out-of-range addresses.

Parameters:
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- DEPTH_LOG2, 12: log2 of memory depth in 64-bit words.
- READ_LATENCY, 2: idle cycles between AR handshake and first R beat (0..15).
- WRITE_LATENCY, 1: idle cycles between last W handshake and bvalid (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- in_awready out 1, in_awvalid in 1, in_awid in 4, in_awaddr in 32, in_awlen in 8, in_awsize in 3, in_awburst in 2: AW channel
- in_wready out 1, in_wvalid in 1, in_wdata in 64, in_wstrb in 8, in_wlast in 1: W channel
- in_bready in 1, in_bvalid out 1, in_bid out 4, in_bresp out 2: B channel
- in_arready out 1, in_arvalid in 1, in_arid in 4, in_araddr in 32, in_arlen in 8, in_arsize in 3, in_arburst in 2: AR channel
- in_rready in 1, in_rvalid out 1, in_rid out 4, in_rdata out 64, in_rresp out 2, in_rlast out 1: R channel

Behaviour:
- Reset values: in_arready=1, in_awready=1, in_wready=0, in_rvalid=0, in_bvalid=0; all id/data/resp/last outputs 0. Memory contents are not reset.
- Reset asserted mid-burst aborts the transaction immediately; no partial B or R response follows.
- Address decode:
  - word index = (addr-BASE_ADDR)>>3, truncated to DEPTH_LOG2 bits.
  - in range iff BASE_ADDR <= addr < BASE_ADDR + 8<<DEPTH_LOG2, checked on every beat.
- Beat address advance:
  - FIXED (00): address unchanged.
  - INCR (01): address += 1<<size.
  - WRAP (10) and reserved (11): address advances as INCR; response is SLVERR (2'b10) on every beat / on B.
  - size > 3: treated as 3, SLVERR.
- Read FSM R_IDLE -> R_WAIT -> R_BURST:
  - R_IDLE: arready=1. On AR handshake, latch id/addr/len/size/burst, load counter with READ_LATENCY, arready->0.
  - R_WAIT: decrement counter; at 0 go to R_BURST. With READ_LATENCY=0, the first rvalid is in the cycle after the AR handshake; in general it is AR cycle +1+READ_LATENCY.
  - R_BURST: rvalid=1. rdata/rresp/rlast stay stable until rready. rlast=1 on beat arlen (len+1 beats total). Out-of-range beat: rdata=0, rresp=DECERR (2'b11).
  - Back-to-back beats: one beat per cycle while rready=1.
  - After the last handshake: R_IDLE, arready=1 on the next cycle.
- Write FSM W_IDLE -> W_DATA -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch fields; wready=1 from the next cycle.
  - W_DATA: each wvalid&&wready writes the bytes selected by wstrb at that clock edge.
    - Out-of-range beats are dropped and set the sticky DECERR flag.
    - The burst ends on the beat where the count reaches awlen.
    - SLVERR if wlast=0 on that beat or wlast=1 on any earlier beat.
    - Earlier beats are still written.
  - W_WAIT: WRITE_LATENCY cycles.
  - W_RESP: bvalid=1, bid=latched awid. bresp priority: DECERR > SLVERR > OKAY. Held until bready, then W_IDLE.
- W beats arriving before the AW handshake are not accepted (wready=0).
- Same-cycle read beat launch and write to the same word: the read returns the old data (read sampled before the write commits).
- AR and AW handshakes may occur in the same cycle; both are accepted.

Optional Feature:
- Macro AXI4_SRAM_STALL_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advancing every cycle) gates the channels.
  - LFSR bit0=1 forces wready=0 and blocks the launch of the next R beat.
  - A beat already presented stays valid and stable.
  - Latency counts are unaffected.
- When undefined: no stalls; the LFSR is not instantiated.

Test Plan:
- Single read: AR addr=0x8000_0008, len=0, id=3, READ_LATENCY=2, mem[1]=0x1122334455667788 -> rvalid 3 cycles after AR handshake, rdata=0x1122334455667788, rid=3, rlast=1, rresp=0.
- INCR write, len=3, wstrb=0xFF, data 1..4 at 0x8000_0100, then INCR read of the same range -> bresp=0, bid echoed, read beats 1,2,3,4, rlast only on beat 4.
- Partial strobe: write wstrb=0x0F, data 0xFFFF_FFFF_FFFF_FFFF over a word holding 0 -> read returns 0x0000_0000_FFFF_FFFF.
- Out of range: read at 0x7FFF_FFF8, len=1 -> two beats, rdata=0, rresp=2'b11; write there -> bresp=2'b11, memory unchanged.
- Early wlast on beat 1 of a len=2 write -> all 3 beats written, bresp=2'b10. Separately, with rready held low 5 cycles mid-burst -> rdata stable, no beat lost.
- Reset asserted during R_BURST of a len=7 read -> rvalid=0 immediately, arready=1 after release, and a new read completes normally.
